// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stall, branch flush and memory freeze.
// Optional statistics counters are enabled with the HAZ_STATS_EN macro.
module hazard_ctrl #(
    parameter int unsigned STALL_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [31:0]       id_asel,
    input  logic [31:0]       id_bsel,
    input  logic              id_use_b,
    input  logic              ex_load,
    input  logic [31:0]       ex_dsel,
    input  logic              ex_br_taken,
    input  logic              mem_busy,
    output logic              pc_we,
    output logic              if_id_we,
    output logic              if_id_flush,
    output logic              id_ex_we,
    output logic              id_ex_bubble,
`ifdef HAZ_STATS_EN
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  freeze_cnt,
`endif
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        FREEZE  = 2'd2,
        ILLEGAL = 2'd3
    } state_t;

    localparam logic [31:0] NZ_MASK      = 32'hFFFF_FFFE;
    localparam logic [3:0]  STALL_RELOAD = 4'(STALL_CYCLES - 1);
    localparam bit          MULTI_STALL  = (STALL_CYCLES > 1);

    if (STALL_CYCLES < 1 || STALL_CYCLES > 15 || CNT_W < 1) begin : g_bad_cfg
        $error("hazard_ctrl: STALL_CYCLES must be 1..15 and CNT_W >= 1");
    end

    state_t     state_q, state_n;
    state_t     ret_q, ret_n;
    state_t     eff_state;
    logic [3:0] cnt_q, cnt_n;
    logic       a_hit, b_hit, hz;

    // r0 is hard-wired zero, so a load targeting it never creates a dependency
    assign a_hit = |(id_asel & ex_dsel & NZ_MASK);
    assign b_hit = id_use_b & (|(id_bsel & ex_dsel & NZ_MASK));
    assign hz    = id_valid & ex_load & (a_hit | b_hit);

    assign state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            ret_q   <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            ret_q   <= ret_n;
            cnt_q   <= cnt_n;
        end
    end

    // On the release cycle of FREEZE the saved state is evaluated in full,
    // so that cycle counts as a normal RUN/LDSTALL cycle.
    always_comb begin
        pc_we        = 1'b0;
        if_id_we     = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_we     = 1'b0;
        id_ex_bubble = 1'b0;
        state_n      = state_q;
        ret_n        = ret_q;
        cnt_n        = cnt_q;
        eff_state    = (state_q == FREEZE) ? ret_q : state_q;

        if (!rst_n) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (mem_busy) begin
            if (state_q != FREEZE) begin
                ret_n   = (state_q == LDSTALL) ? LDSTALL : RUN;
                state_n = FREEZE;
            end
        end else begin
            case (eff_state)
                RUN: begin
                    if (ex_br_taken) begin
                        pc_we        = 1'b1;
                        if_id_we     = 1'b1;
                        if_id_flush  = 1'b1;
                        id_ex_we     = 1'b1;
                        id_ex_bubble = 1'b1;
                        state_n      = RUN;
                        cnt_n        = '0;
                    end else if (hz) begin
                        id_ex_we     = 1'b1;
                        id_ex_bubble = 1'b1;
                        if (MULTI_STALL) begin
                            cnt_n   = STALL_RELOAD;
                            state_n = LDSTALL;
                        end else begin
                            state_n = RUN;
                        end
                    end else begin
                        pc_we    = 1'b1;
                        if_id_we = 1'b1;
                        id_ex_we = 1'b1;
                        state_n  = RUN;
                    end
                end
                LDSTALL: begin
                    if (ex_br_taken) begin
                        pc_we        = 1'b1;
                        if_id_we     = 1'b1;
                        if_id_flush  = 1'b1;
                        id_ex_we     = 1'b1;
                        id_ex_bubble = 1'b1;
                        state_n      = RUN;
                        cnt_n        = '0;
                    end else begin
                        id_ex_we     = 1'b1;
                        id_ex_bubble = 1'b1;
                        cnt_n        = cnt_q - 4'd1;
                        state_n      = (cnt_q <= 4'd1) ? RUN : LDSTALL;
                    end
                end
                default: begin
                    state_n = RUN;
                    ret_n   = RUN;
                    cnt_n   = '0;
                end
            endcase
        end
    end

`ifdef HAZ_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            freeze_cnt <= '0;
        end else begin
            if (id_ex_bubble && !if_id_flush && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (if_id_flush && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
            if (mem_busy && freeze_cnt != '1)
                freeze_cnt <= freeze_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one instance with STALL_CYCLES=1, one with 3.
// Observed vector layout: {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, state}.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid, id_use_b, ex_load, ex_br_taken, mem_busy;
    logic [31:0] id_asel, id_bsel, ex_dsel;

    logic pc_we1, if_id_we1, if_id_flush1, id_ex_we1, id_ex_bubble1;
    logic pc_we3, if_id_we3, if_id_flush3, id_ex_we3, id_ex_bubble3;
    logic [1:0] state1, state3;
`ifdef HAZ_STATS_EN
    logic [15:0] stall_cnt1, flush_cnt1, freeze_cnt1;
    logic [15:0] stall_cnt3, flush_cnt3, freeze_cnt3;
`endif

    int unsigned total = 0;
    int unsigned bad   = 0;

    // expected-vector constants
    localparam logic [6:0] V_RST    = 7'b0010100;
    localparam logic [6:0] V_RUN    = 7'b1101000;
    localparam logic [6:0] V_STL0   = 7'b0001100;
    localparam logic [6:0] V_STL1   = 7'b0001101;
    localparam logic [6:0] V_BR0    = 7'b1111100;
    localparam logic [6:0] V_BR1    = 7'b1111101;
    localparam logic [6:0] V_FRZ1   = 7'b0000001;
    localparam logic [6:0] V_FRZ2   = 7'b0000010;
    localparam logic [6:0] V_BUSY0  = 7'b0000000;
    localparam logic [6:0] V_RELSTL = 7'b0001110;
    localparam logic [6:0] V_RELRUN = 7'b1101010;

    wire [6:0] o1 = {pc_we1, if_id_we1, if_id_flush1, id_ex_we1, id_ex_bubble1, state1};
    wire [6:0] o3 = {pc_we3, if_id_we3, if_id_flush3, id_ex_we3, id_ex_bubble3, state3};

    always #5 clk = ~clk;

    hazard_ctrl #(.STALL_CYCLES(1), .CNT_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_asel(id_asel),
        .id_bsel(id_bsel), .id_use_b(id_use_b), .ex_load(ex_load), .ex_dsel(ex_dsel),
        .ex_br_taken(ex_br_taken), .mem_busy(mem_busy), .pc_we(pc_we1),
        .if_id_we(if_id_we1), .if_id_flush(if_id_flush1), .id_ex_we(id_ex_we1),
        .id_ex_bubble(id_ex_bubble1),
`ifdef HAZ_STATS_EN
        .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1), .freeze_cnt(freeze_cnt1),
`endif
        .state(state1)
    );

    hazard_ctrl #(.STALL_CYCLES(3), .CNT_W(16)) u3 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_asel(id_asel),
        .id_bsel(id_bsel), .id_use_b(id_use_b), .ex_load(ex_load), .ex_dsel(ex_dsel),
        .ex_br_taken(ex_br_taken), .mem_busy(mem_busy), .pc_we(pc_we3),
        .if_id_we(if_id_we3), .if_id_flush(if_id_flush3), .id_ex_we(id_ex_we3),
        .id_ex_bubble(id_ex_bubble3),
`ifdef HAZ_STATS_EN
        .stall_cnt(stall_cnt3), .flush_cnt(flush_cnt3), .freeze_cnt(freeze_cnt3),
`endif
        .state(state3)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle;
        id_valid    = 1'b0;
        id_asel     = '0;
        id_bsel     = '0;
        id_use_b    = 1'b0;
        ex_load     = 1'b0;
        ex_dsel     = '0;
        ex_br_taken = 1'b0;
        mem_busy    = 1'b0;
    endtask

    task automatic drive_hz_a(input int unsigned r);
        drive_idle();
        id_valid = 1'b1;
        ex_load  = 1'b1;
        ex_dsel  = 32'd1 << r;
        id_asel  = 32'd1 << r;
    endtask

    task automatic apply_reset;
        drive_idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        drive_idle();
        rst_n = 1'b0;
        #1;
        total++;
        if (o1 !== V_RST) begin bad++; $display("FAIL reset_u1 got=%b exp=%b", o1, V_RST); end
        total++;
        if (o3 !== V_RST) begin bad++; $display("FAIL reset_u3 got=%b exp=%b", o3, V_RST); end
        tick();
        rst_n = 1'b1;
        tick();
        total++;
        if (o1 !== V_RUN) begin bad++; $display("FAIL reset_release_u1 got=%b exp=%b", o1, V_RUN); end
        total++;
        if (o3 !== V_RUN) begin bad++; $display("FAIL reset_release_u3 got=%b exp=%b", o3, V_RUN); end
    endtask

    task automatic test_load_use;
        apply_reset();
        drive_hz_a(5);
        #1;
        total++;
        if (o1 !== V_STL0) begin bad++; $display("FAIL load_use_stall got=%b exp=%b", o1, V_STL0); end
        tick();
        ex_load = 1'b0;
        #1;
        total++;
        if (o1 !== V_RUN) begin bad++; $display("FAIL load_use_resume got=%b exp=%b", o1, V_RUN); end
    endtask

    task automatic test_exclusion;
        apply_reset();
        drive_hz_a(0);
        #1;
        total++;
        if (o1 !== V_RUN) begin bad++; $display("FAIL excl_r0 got=%b exp=%b", o1, V_RUN); end
        tick();
        drive_idle();
        id_valid = 1'b1;
        ex_load  = 1'b1;
        ex_dsel  = 32'd1 << 7;
        id_bsel  = 32'd1 << 7;
        id_asel  = 32'd1 << 3;
        id_use_b = 1'b0;
        #1;
        total++;
        if (o1 !== V_RUN) begin bad++; $display("FAIL excl_imm got=%b exp=%b", o1, V_RUN); end
        tick();
        id_use_b = 1'b1;
        #1;
        total++;
        if (o1 !== V_STL0) begin bad++; $display("FAIL excl_useb got=%b exp=%b", o1, V_STL0); end
        tick();
        id_valid = 1'b0;
        #1;
        total++;
        if (o1 !== V_RUN) begin bad++; $display("FAIL excl_invalid got=%b exp=%b", o1, V_RUN); end
        tick();
        drive_hz_a(31);
        #1;
        total++;
        if (o1 !== V_STL0) begin bad++; $display("FAIL excl_r31 got=%b exp=%b", o1, V_STL0); end
        tick();
        drive_idle();
    endtask

    task automatic test_multi_stall;
        logic [6:0] exp_v [4] = '{V_STL0, V_STL1, V_STL1, V_RUN};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            if (i == 0) drive_hz_a(9);
            else        drive_idle();
            #1;
            total++;
            if (o3 !== exp_v[i]) begin
                bad++;
                $display("FAIL multi_stall[%0d] got=%b exp=%b", i, o3, exp_v[i]);
            end
            tick();
        end
    endtask

    task automatic test_branch;
        apply_reset();
        drive_hz_a(4);
        ex_br_taken = 1'b1;
        #1;
        total++;
        if (o3 !== V_BR0) begin bad++; $display("FAIL branch_beats_hz got=%b exp=%b", o3, V_BR0); end
        tick();
        drive_idle();
        #1;
        total++;
        if (o3 !== V_RUN) begin bad++; $display("FAIL branch_no_residual got=%b exp=%b", o3, V_RUN); end
        tick();
        drive_hz_a(4);
        #1;
        tick();
        drive_idle();
        ex_br_taken = 1'b1;
        #1;
        total++;
        if (o3 !== V_BR1) begin bad++; $display("FAIL branch_in_ldstall got=%b exp=%b", o3, V_BR1); end
        tick();
        drive_idle();
        #1;
        total++;
        if (o3 !== V_RUN) begin bad++; $display("FAIL branch_cancels_stall got=%b exp=%b", o3, V_RUN); end
    endtask

    task automatic test_freeze;
        logic [6:0] exp_v [8] = '{V_STL0, V_FRZ1, V_FRZ2, V_FRZ2, V_FRZ2, V_RELSTL, V_STL1, V_RUN};
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            if (i == 0) drive_hz_a(12);
            else        drive_idle();
            mem_busy = (i >= 1 && i <= 4);
            #1;
            total++;
            if (o3 !== exp_v[i]) begin
                bad++;
                $display("FAIL freeze_ldstall[%0d] got=%b exp=%b", i, o3, exp_v[i]);
            end
            tick();
        end
        drive_idle();
        mem_busy    = 1'b1;
        ex_br_taken = 1'b1;
        #1;
        total++;
        if (o3 !== V_BUSY0) begin bad++; $display("FAIL freeze_beats_branch got=%b exp=%b", o3, V_BUSY0); end
        tick();
        drive_idle();
        #1;
        total++;
        if (o3 !== V_RELRUN) begin bad++; $display("FAIL freeze_release_run got=%b exp=%b", o3, V_RELRUN); end
        tick();
        #1;
        total++;
        if (o3 !== V_RUN) begin bad++; $display("FAIL freeze_back_run got=%b exp=%b", o3, V_RUN); end
    endtask

    task automatic test_reset_mid_stall;
        apply_reset();
        drive_hz_a(20);
        #1;
        tick();
        drive_idle();
        #1;
        total++;
        if (o3 !== V_STL1) begin bad++; $display("FAIL mid_stall_pre got=%b exp=%b", o3, V_STL1); end
        rst_n = 1'b0;
        #1;
        total++;
        if (o3 !== V_RST) begin bad++; $display("FAIL mid_stall_reset got=%b exp=%b", o3, V_RST); end
`ifdef HAZ_STATS_EN
        total++;
        if ({stall_cnt3, flush_cnt3, freeze_cnt3} !== 48'd0) begin
            bad++;
            $display("FAIL stats_reset got=%h/%h/%h exp=0", stall_cnt3, flush_cnt3, freeze_cnt3);
        end
`endif
        tick();
        rst_n = 1'b1;
        tick();
        total++;
        if (o3 !== V_RUN) begin bad++; $display("FAIL mid_stall_release got=%b exp=%b", o3, V_RUN); end
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_load_use();
        test_exclusion();
        test_multi_stall();
        test_branch();
        test_freeze();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
